// File: rtl/mc_native_arb.sv
// mc_native_arb: two-port weighted round-robin command arbiter with burst
// credit, starvation override and one registered output stage toward the
// memory-controller command queue.
// Optional feature macro: MC_NATIVE_ARB_STATS_EN adds per-port saturating
// grant counters (o_grant_cnt0/o_grant_cnt1) with a synchronous clear.
// Handshake: a command moves on a rising edge where valid and ready are both 1.
// Ready on p0/p1 is combinational and asserted only for the port chosen this
// cycle. m_cmd_* holds steady while m_cmd_valid=1 and m_cmd_ready=0.
module mc_native_arb #(
    parameter int AW     = 32,
    parameter int WCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_cmd_valid,
    output logic              p0_cmd_ready,
    input  logic              p0_cmd_we,
    input  logic [AW-1:0]     p0_cmd_addr,
    input  logic              p1_cmd_valid,
    output logic              p1_cmd_ready,
    input  logic              p1_cmd_we,
    input  logic [AW-1:0]     p1_cmd_addr,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic              m_cmd_we,
    output logic [AW-1:0]     m_cmd_addr,
    output logic              m_cmd_port,
    input  logic [3:0]        cfg_weight0,
    input  logic [3:0]        cfg_weight1,
    input  logic [WCNT_W-1:0] cfg_starve_lim,
    output logic              o_starve_evt
`ifdef MC_NATIVE_ARB_STATS_EN
    ,
    input  logic              i_stats_clr,
    output logic [15:0]       o_grant_cnt0,
    output logic [15:0]       o_grant_cnt1
`endif
);

    // Arbitration state: current burst owner and remaining consecutive grants.
    logic              owner;
    logic [3:0]        credit;
    logic [WCNT_W-1:0] wait_cnt [2];

    logic              load;
    logic              gnt;
    logic              gnt_port;
    logic              gnt_starve;
    logic              owner_nxt;
    logic [3:0]        credit_nxt;
    logic              req [2];
    logic              starve [2];
    logic [3:0]        w_eff [2];
    logic              sel_we;
    logic [AW-1:0]     sel_addr;

    // Request vector, effective weights (0 behaves as 1) and starvation flags.
    always_comb begin
        req[0]    = p0_cmd_valid;
        req[1]    = p1_cmd_valid;
        w_eff[0]  = (cfg_weight0 == 4'd0) ? 4'd1 : cfg_weight0;
        w_eff[1]  = (cfg_weight1 == 4'd0) ? 4'd1 : cfg_weight1;
        starve[0] = (cfg_starve_lim != '0) && (wait_cnt[0] >= cfg_starve_lim);
        starve[1] = (cfg_starve_lim != '0) && (wait_cnt[1] >= cfg_starve_lim);
    end

    // Grant selection in priority order: starvation, owner credit, other port, owner reload.
    always_comb begin
        load       = !m_cmd_valid || m_cmd_ready;
        gnt        = 1'b0;
        gnt_port   = owner;
        gnt_starve = 1'b0;
        owner_nxt  = owner;
        credit_nxt = credit;
        if (load) begin
            if (starve[!owner] && req[!owner]) begin
                gnt        = 1'b1;
                gnt_port   = !owner;
                gnt_starve = 1'b1;
                owner_nxt  = !owner;
                credit_nxt = w_eff[!owner] - 4'd1;
            end else if (req[owner] && credit != 4'd0) begin
                gnt        = 1'b1;
                gnt_port   = owner;
                credit_nxt = credit - 4'd1;
            end else if (req[!owner]) begin
                gnt        = 1'b1;
                gnt_port   = !owner;
                owner_nxt  = !owner;
                credit_nxt = w_eff[!owner] - 4'd1;
            end else if (req[owner]) begin
                gnt        = 1'b1;
                gnt_port   = owner;
                credit_nxt = w_eff[owner] - 4'd1;
            end
        end
    end

    // Ready pulses and payload mux; rst_n gating keeps readies low during reset.
    always_comb begin
        p0_cmd_ready = rst_n && gnt && (gnt_port == 1'b0);
        p1_cmd_ready = rst_n && gnt && (gnt_port == 1'b1);
        sel_we       = gnt_port ? p1_cmd_we   : p0_cmd_we;
        sel_addr     = gnt_port ? p1_cmd_addr : p0_cmd_addr;
    end

    // Output register; the starvation pulse is registered so it lines up with the forced command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd_valid  <= 1'b0;
            m_cmd_we     <= 1'b0;
            m_cmd_addr   <= '0;
            m_cmd_port   <= 1'b0;
            o_starve_evt <= 1'b0;
        end else begin
            o_starve_evt <= gnt_starve;
            if (load) begin
                m_cmd_valid <= gnt;
            end
            if (gnt) begin
                m_cmd_we   <= sel_we;
                m_cmd_addr <= sel_addr;
                m_cmd_port <= gnt_port;
            end
        end
    end

    // Owner/credit update; owner resets to 1 so port 0 wins the first simultaneous request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= 1'b1;
            credit <= 4'd0;
        end else if (gnt) begin
            owner  <= owner_nxt;
            credit <= credit_nxt;
        end
    end

    // Starvation wait counters: clear on own grant, saturating count of grants lost while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt[0] <= '0;
            wait_cnt[1] <= '0;
        end else if (gnt) begin
            for (int p = 0; p < 2; p++) begin
                if (gnt_port == p[0]) begin
                    wait_cnt[p] <= '0;
                end else if (req[p] && wait_cnt[p] != {WCNT_W{1'b1}}) begin
                    wait_cnt[p] <= wait_cnt[p] + 1'b1;
                end
            end
        end
    end

`ifdef MC_NATIVE_ARB_STATS_EN
    // Saturating per-port grant counters; clear takes precedence over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_grant_cnt0 <= '0;
            o_grant_cnt1 <= '0;
        end else if (i_stats_clr) begin
            o_grant_cnt0 <= '0;
            o_grant_cnt1 <= '0;
        end else if (gnt) begin
            if (!gnt_port && o_grant_cnt0 != 16'hFFFF) begin
                o_grant_cnt0 <= o_grant_cnt0 + 16'd1;
            end
            if (gnt_port && o_grant_cnt1 != 16'hFFFF) begin
                o_grant_cnt1 <= o_grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule
